// File: rtl/uart_wb_master.sv
// rtl/uart_wb_master.sv - Request FIFO driving single Wishbone cycles to a UART core, with ack timeout
module uart_wb_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic       clock,
    input  logic       wb_rst_n_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic       req_we_i,
    input  logic [2:0] req_addr_i,
    input  logic [7:0] req_data_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_data_o,
    output logic       rsp_err_o,
    output logic [2:0] wb_addr_o,
    output logic [7:0] wb_dat_o,
    output logic [3:0] wb_sel_o,
    output logic       wb_we_o,
    output logic       wb_stb_o,
    output logic       wb_cyc_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = 1;
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [11:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        ready_q, ready_d;
    logic [7:0]  timer_q, timer_d;
    logic [2:0]  wb_addr_q, wb_addr_d;
    logic [7:0]  wb_dat_q, wb_dat_d;
    logic        wb_we_q, wb_we_d;
    logic        cyc_q, cyc_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic        push, pop, empty;
    logic [11:0] head;

    assign push  = req_valid_i && ready_q;
    assign pop   = (state_q == S_RESP);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // Ready is registered from the post-edge occupancy, so a pop frees a slot one cycle later.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ready_d  = ((wr_ptr_d - rd_ptr_d) != FULL_CNT);
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        wb_addr_d   = wb_addr_q;
        wb_dat_d    = wb_dat_q;
        wb_we_d     = wb_we_q;
        cyc_d       = cyc_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 8'h00;
        rsp_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    state_d   = S_BUS;
                    cyc_d     = 1'b1;
                    wb_we_d   = head[11];
                    wb_addr_d = head[10:8];
                    wb_dat_d  = head[7:0];
                    timer_d   = 8'h00;
                end
            end
            S_BUS: begin
                timer_d = timer_q + 8'd1;
                // Ack wins over timeout expiry on the same edge.
                if (wb_ack_i || (timer_q == TMO_LAST)) begin
                    state_d     = S_RESP;
                    cyc_d       = 1'b0;
                    wb_we_d     = 1'b0;
                    wb_addr_d   = 3'd0;
                    wb_dat_d    = 8'h00;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !wb_ack_i;
                    rsp_data_d  = (wb_ack_i && !wb_we_q) ? wb_dat_i : 8'h00;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {req_we_i, req_addr_i, req_data_i};
        end
    end

    always_ff @(posedge clock or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ready_q     <= 1'b0;
            timer_q     <= 8'h00;
            wb_addr_q   <= 3'd0;
            wb_dat_q    <= 8'h00;
            wb_we_q     <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ready_q     <= ready_d;
            timer_q     <= timer_d;
            wb_addr_q   <= wb_addr_d;
            wb_dat_q    <= wb_dat_d;
            wb_we_q     <= wb_we_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign wb_addr_o   = wb_addr_q;
    assign wb_dat_o    = wb_dat_q;
    assign wb_we_o     = wb_we_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_sel_o    = cyc_q ? 4'b0001 : 4'b0000;

endmodule

// File: doc/uart_wb_master.md
UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the number of request entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 16, sets the cycles a bus cycle waits for ack before it is abandoned (2..255).
REQ-003 clock  input  1  Single clock; all state updates on the rising edge.
REQ-004 wb_rst_n_i  input  1  Reset, asynchronous assert, active-low.
REQ-005 req_valid_i  input  1  Request present.
REQ-006 req_ready_o  output  1  Request FIFO can accept; equals not-full.
REQ-007 req_we_i  input  1  1 = register write, 0 = register read.
REQ-008 req_addr_i  input  3  UART register address.
REQ-009 req_data_i  input  8  Write data; ignored for reads.
REQ-010 rsp_valid_o  output  1  One-cycle pulse per completed request; no backpressure.
REQ-011 rsp_data_o  output  8  Read data; 8'h00 for writes and timeouts.
REQ-012 rsp_err_o  output  1  Qualified by rsp_valid_o; 1 = no ack within TIMEOUT.
REQ-013 wb_addr_o  output  3  Bus address to UART core.
REQ-014 wb_dat_o  output  8  Bus write data to UART core.
REQ-015 wb_sel_o  output  4  Byte select; constant 4'b0001 during a cycle, 4'b0000 otherwise.
REQ-016 wb_we_o, wb_stb_o, wb_cyc_o  output  1 each  Wishbone cycle controls.
REQ-017 wb_dat_i  input  8  Read data from UART core.
REQ-018 wb_ack_i  input  1  Transfer acknowledge from UART core.

Function
REQ-019 Request accepted (FIFO push) on a rising edge where req_valid_i and req_ready_o are both 1; entries are {we, addr, data}.
REQ-020 FSM states: IDLE, BUS, RESP.
REQ-021 IDLE -> BUS on the edge where the FIFO is non-empty; the head entry drives wb_addr_o/wb_dat_o/wb_we_o from that edge.
REQ-022 In BUS: wb_cyc_o = wb_stb_o = 1; address, data and we held stable; timeout counter cleared on entry, increments each cycle.
REQ-023 BUS -> RESP on the first edge with wb_ack_i = 1; a read captures wb_dat_i on that edge; rsp_err = 0.
REQ-024 BUS -> RESP with rsp_err = 1 when TIMEOUT cycles elapse in BUS with no ack; rsp_data = 8'h00.
REQ-025 wb_cyc_o, wb_stb_o and wb_we_o deassert on the same edge that leaves BUS; minimum one idle cycle between bus cycles.
REQ-026 In RESP: rsp_valid_o = 1 for exactly one cycle; the FIFO pops on the edge leaving RESP; RESP -> IDLE unconditionally.
REQ-027 Latency: push at edge N into an empty FIFO gives cyc high after edge N+1; ack sampled at edge M gives rsp_valid high in cycle M..M+1.
REQ-028 Simultaneous push and pop is allowed; occupancy is unchanged; a full FIFO accepts a push on the same edge as a pop only in the following cycle (req_ready_o is registered from occupancy).
REQ-029 When full, req_ready_o = 0 and req_valid_i is ignored; no overwrite.
REQ-030 Pointers wrap modulo FIFO_DEPTH; a full/empty distinction uses an extra pointer bit.
REQ-031 wb_ack_i is ignored outside BUS; an ack on the same edge as timeout expiry counts as success.
REQ-032 Responses are returned strictly in request order.

Reset
REQ-033 While wb_rst_n_i = 0: FSM = IDLE, FIFO empty, all wb_* outputs 0, rsp_valid_o = 0, rsp_data_o = 8'h00, rsp_err_o = 0, req_ready_o = 0.
REQ-034 req_ready_o rises the first edge after reset release.
REQ-035 Reset asserted mid-BUS drops wb_cyc_o/wb_stb_o immediately (asynchronously); the in-flight and queued requests are discarded with no response.

Verification
REQ-036 Write addr 3 data 8'h83, ack after 2 cycles -> one cyc/stb cycle with we = 1, addr = 3, dat = 8'h83, sel = 4'b0001; rsp_valid with err = 0.
REQ-037 Read addr 5, ack with wb_dat_i = 8'h60 -> rsp_data_o = 8'h60, err = 0, exactly one pulse.
REQ-038 No ack, TIMEOUT = 16 -> cyc high 16 cycles, then rsp_valid with err = 1, data = 8'h00.
REQ-039 Push 5 requests back-to-back with FIFO_DEPTH = 4 and ack held off -> req_ready_o = 0 after the 4th; 5th accepted after the first response; all 5 complete in order.
REQ-040 Reset pulse while cyc high with 3 queued -> outputs zero immediately; no rsp_valid after release; the next request is handled normally.
REQ-041 Spurious wb_ack_i in IDLE -> no response, no state change.
